execute_stage_mc: RTL and testbench

Parametrised execute stage for the pipelined ARM-subset core. It replaces the single-cycle execute stage. It keeps operand forwarding, the ALU, condition evaluation with flag write-back and the E/M pipeline register. It adds an iterative multi-cycle multiplier that stalls the front end, a stage flush, and valid tracking into M.

---
 rtl/execute_stage_mc.sv | 209 ++++++++++++++++++++
 tb/tb_execute_stage_mc.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/execute_stage_mc.sv
// Execute stage with forwarding, ALU, ARM condition/flag logic, an iterative multiplier and the E/M register.
// Optional: define EXEC_STALL_CNT_EN to add the 32-bit StallCnt output.
module execute_stage_mc #(
    parameter int WIDTH     = 32,
    parameter int WA_W      = 4,
    parameter int MUL_STEPS = WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ValidE,
    input  logic [WIDTH-1:0] RD1E,
    input  logic [WIDTH-1:0] RD2E,
    input  logic [WIDTH-1:0] ExtImmE,
    input  logic [WIDTH-1:0] ResultW,
    input  logic [WIDTH-1:0] ALUResultMFB,
    input  logic [1:0]       ForwardAE,
    input  logic [1:0]       ForwardBE,
    input  logic             ALUSrcE,
    input  logic [2:0]       ALUControlE,
    input  logic [1:0]       FlagWriteE,
    input  logic [3:0]       CondE,
    input  logic             PCSrcE,
    input  logic             RegWriteE,
    input  logic             MemWriteE,
    input  logic             MemtoRegE,
    input  logic             BranchE,
    input  logic [WA_W-1:0]  WA3E,
    input  logic             FlushE,
    output logic             StallE,
    output logic             BranchTakenE,
    output logic [WIDTH-1:0] ALUResultEA,
    output logic [3:0]       FlagsD,
    output logic             ValidM,
    output logic             PCSrcM,
    output logic             RegWriteM,
    output logic             MemWriteM,
    output logic             MemtoRegM,
    output logic [WIDTH-1:0] ALUResultM,
    output logic [WIDTH-1:0] WriteDataM,
    output logic [WA_W-1:0]  WA3M
`ifdef EXEC_STALL_CNT_EN
    ,
    output logic [31:0]      StallCnt
`endif
);

    localparam int CHUNK = WIDTH / MUL_STEPS;
    localparam int CNT_W = (MUL_STEPS > 2) ? $clog2(MUL_STEPS) : 1;

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DONE} state_t;

    state_t             state, state_next;
    logic [CNT_W-1:0]   cnt;
    logic [WIDTH-1:0]   mcand, mplier, acc;
    logic [3:0]         nzcv;

    logic [WIDTH-1:0]   op1, op2, write_data_e, b_eff, alu_res, result_e;
    logic [WIDTH:0]     sum;
    logic               is_sub, alu_c, alu_v, is_mul, mul_start, issue_ok, cond_ex, executed;
    logic [WIDTH-1:0]   step_a, step_b, step_acc, chunk_ext, step_sum;

    assign op1 = (ForwardAE == 2'b01) ? ResultW :
                 (ForwardAE == 2'b10) ? ALUResultMFB : RD1E;
    assign write_data_e = (ForwardBE == 2'b01) ? ResultW :
                          (ForwardBE == 2'b10) ? ALUResultMFB : RD2E;
    assign op2 = ALUSrcE ? ExtImmE : write_data_e;

    // SUB is a + ~b + 1 so the carry out reads as "no borrow".
    assign is_sub = (ALUControlE == 3'b001);
    assign b_eff  = is_sub ? ~op2 : op2;
    assign sum    = {1'b0, op1} + {1'b0, b_eff} + {{WIDTH{1'b0}}, is_sub};

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        alu_res = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        case (ALUControlE)
            3'b000, 3'b001: begin
                alu_res = sum[WIDTH-1:0];
                alu_c   = sum[WIDTH];
                alu_v   = (op1[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != op1[WIDTH-1]);
            end
            3'b010:  alu_res = op1 & op2;
            3'b011:  alu_res = op1 | op2;
            default: alu_res = '0;
        endcase
    end

    function automatic logic cond_eval(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cy, v;
        {n, z, cy, v} = f;
        case (c)
            4'b0000: cond_eval = z;
            4'b0001: cond_eval = ~z;
            4'b0010: cond_eval = cy;
            4'b0011: cond_eval = ~cy;
            4'b0100: cond_eval = n;
            4'b0101: cond_eval = ~n;
            4'b0110: cond_eval = v;
            4'b0111: cond_eval = ~v;
            4'b1000: cond_eval = cy & ~z;
            4'b1001: cond_eval = ~cy | z;
            4'b1010: cond_eval = (n == v);
            4'b1011: cond_eval = (n != v);
            4'b1100: cond_eval = ~z & (n == v);
            4'b1101: cond_eval = z | (n != v);
            4'b1110: cond_eval = 1'b1;
            default: cond_eval = 1'b0;
        endcase
    endfunction

    assign is_mul    = (ALUControlE == 3'b100);
    assign mul_start = (state == S_IDLE) && ValidE && is_mul && !FlushE;
    assign issue_ok  = ((state == S_IDLE) && !is_mul) || (state == S_DONE);
    assign cond_ex   = cond_eval(CondE, nzcv);
    assign executed  = ValidE && cond_ex && !FlushE && issue_ok;

    // One multiplier step: the start cycle consumes the live operands, later cycles the latched ones.
    always_comb begin
        step_a    = (state == S_IDLE) ? op1 : mcand;
        step_b    = (state == S_IDLE) ? op2 : mplier;
        step_acc  = (state == S_IDLE) ? '0  : acc;
        chunk_ext = '0;
        chunk_ext[CHUNK-1:0] = step_b[CHUNK-1:0];
        step_sum  = step_acc + step_a * chunk_ext;
    end

    always_comb begin
        state_next = state;
        StallE     = 1'b0;
        case (state)
            S_IDLE: begin
                StallE = mul_start;
                if (mul_start) state_next = (MUL_STEPS == 1) ? S_DONE : S_MUL;
            end
            S_MUL: begin
                StallE = 1'b1;
                if (FlushE)                               state_next = S_IDLE;
                else if (cnt == CNT_W'(MUL_STEPS - 2))    state_next = S_DONE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    assign result_e     = (state == S_DONE) ? acc : alu_res;
    assign ALUResultEA  = result_e;
    assign BranchTakenE = BranchE && executed;
    assign FlagsD       = nzcv;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= S_IDLE;
            cnt    <= '0;
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
        end else begin
            state <= state_next;
            if (mul_start || state == S_MUL) begin
                acc    <= step_sum;
                mcand  <= step_a << CHUNK;
                mplier <= step_b >> CHUNK;
                cnt    <= mul_start ? '0 : cnt + 1'b1;
            end
        end
    end

    // A completing MUL only touches N,Z; C,V keep their previous values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            nzcv <= 4'b0000;
        end else if (executed) begin
            if (FlagWriteE[1]) nzcv[3:2] <= {result_e[WIDTH-1], result_e == '0};
            if (FlagWriteE[0] && state != S_DONE) nzcv[1:0] <= {alu_c, alu_v};
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ValidM     <= 1'b0;
            PCSrcM     <= 1'b0;
            RegWriteM  <= 1'b0;
            MemWriteM  <= 1'b0;
            MemtoRegM  <= 1'b0;
            ALUResultM <= '0;
            WriteDataM <= '0;
            WA3M       <= '0;
        end else begin
            ValidM     <= executed;
            PCSrcM     <= PCSrcE    && executed;
            RegWriteM  <= RegWriteE && executed;
            MemWriteM  <= MemWriteE && executed;
            MemtoRegM  <= MemtoRegE && executed;
            ALUResultM <= result_e;
            WriteDataM <= write_data_e;
            WA3M       <= WA3E;
        end
    end

`ifdef EXEC_STALL_CNT_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)                          StallCnt <= '0;
        else if (StallE && StallCnt != '1)   StallCnt <= StallCnt + 32'd1;
    end
`endif

endmodule

// File: tb/tb_execute_stage_mc.sv
// Directed scoreboard bench for execute_stage_mc (WIDTH=32, MUL_STEPS=32); checks StallCnt when EXEC_STALL_CNT_EN is defined.
module tb_execute_stage_mc;

    localparam int W  = 32;
    localparam int MS = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic          ValidE;
    logic [W-1:0]  RD1E, RD2E, ExtImmE, ResultW, ALUResultMFB;
    logic [1:0]    ForwardAE, ForwardBE;
    logic          ALUSrcE;
    logic [2:0]    ALUControlE;
    logic [1:0]    FlagWriteE;
    logic [3:0]    CondE;
    logic          PCSrcE, RegWriteE, MemWriteE, MemtoRegE, BranchE;
    logic [3:0]    WA3E;
    logic          FlushE;
    logic          StallE, BranchTakenE;
    logic [W-1:0]  ALUResultEA;
    logic [3:0]    FlagsD;
    logic          ValidM, PCSrcM, RegWriteM, MemWriteM, MemtoRegM;
    logic [W-1:0]  ALUResultM, WriteDataM;
    logic [3:0]    WA3M;
`ifdef EXEC_STALL_CNT_EN
    logic [31:0]   StallCnt;
`endif

    execute_stage_mc #(.WIDTH(W), .WA_W(4), .MUL_STEPS(MS)) dut (
        .clk(clk), .reset(reset), .ValidE(ValidE),
        .RD1E(RD1E), .RD2E(RD2E), .ExtImmE(ExtImmE), .ResultW(ResultW), .ALUResultMFB(ALUResultMFB),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE), .ALUSrcE(ALUSrcE), .ALUControlE(ALUControlE),
        .FlagWriteE(FlagWriteE), .CondE(CondE), .PCSrcE(PCSrcE), .RegWriteE(RegWriteE),
        .MemWriteE(MemWriteE), .MemtoRegE(MemtoRegE), .BranchE(BranchE), .WA3E(WA3E), .FlushE(FlushE),
        .StallE(StallE), .BranchTakenE(BranchTakenE), .ALUResultEA(ALUResultEA), .FlagsD(FlagsD),
        .ValidM(ValidM), .PCSrcM(PCSrcM), .RegWriteM(RegWriteM), .MemWriteM(MemWriteM),
        .MemtoRegM(MemtoRegM), .ALUResultM(ALUResultM), .WriteDataM(WriteDataM), .WA3M(WA3M)
`ifdef EXEC_STALL_CNT_EN
        , .StallCnt(StallCnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        valid, pcsrc, regwrite, memwrite, memtoreg;
        logic [31:0] result, wdata;
        logic [3:0]  wa;
        bit          chk_data;
        string       tag;
    } m_exp_t;

    m_exp_t sb_q[$];
    int     n_cmp = 0;
    int     n_err = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input string tag, input logic v, pcs, rw, mw, m2r,
                            input logic [31:0] res, wd, input logic [3:0] wa);
        m_exp_t e;
        e.valid = v; e.pcsrc = pcs; e.regwrite = rw; e.memwrite = mw; e.memtoreg = m2r;
        e.result = res; e.wdata = wd; e.wa = wa; e.chk_data = 1'b1; e.tag = tag;
        sb_q.push_back(e);
    endtask

    task automatic push_bubble(input string tag);
        m_exp_t e;
        e.valid = 0; e.pcsrc = 0; e.regwrite = 0; e.memwrite = 0; e.memtoreg = 0;
        e.result = '0; e.wdata = '0; e.wa = '0; e.chk_data = 1'b0; e.tag = tag;
        sb_q.push_back(e);
    endtask

    // Clock one edge, then pop the oldest expectation and compare it with the E/M register.
    task automatic tick();
        m_exp_t e;
        @(posedge clk);
        #1;
        check("sb_nonempty", 64'(sb_q.size() != 0), 64'd1);
        if (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            check({e.tag, ".ValidM"},    64'(ValidM),    64'(e.valid));
            check({e.tag, ".PCSrcM"},    64'(PCSrcM),    64'(e.pcsrc));
            check({e.tag, ".RegWriteM"}, 64'(RegWriteM), 64'(e.regwrite));
            check({e.tag, ".MemWriteM"}, 64'(MemWriteM), 64'(e.memwrite));
            check({e.tag, ".MemtoRegM"}, 64'(MemtoRegM), 64'(e.memtoreg));
            if (e.chk_data) begin
                check({e.tag, ".ALUResultM"}, 64'(ALUResultM), 64'(e.result));
                check({e.tag, ".WriteDataM"}, 64'(WriteDataM), 64'(e.wdata));
                check({e.tag, ".WA3M"},       64'(WA3M),       64'(e.wa));
            end
        end
    endtask

    task automatic drive(input logic [2:0] alu, input logic [1:0] fa, input logic [31:0] rd1, rd2,
                         input logic src_imm, input logic [31:0] imm, input logic [1:0] fw,
                         input logic [3:0] cond, input logic br, pcs, rw, mw, m2r, input logic [3:0] wa);
        ValidE = 1; ALUControlE = alu; ForwardAE = fa; ForwardBE = 2'b00;
        RD1E = rd1; RD2E = rd2; ALUSrcE = src_imm; ExtImmE = imm; FlagWriteE = fw; CondE = cond;
        BranchE = br; PCSrcE = pcs; RegWriteE = rw; MemWriteE = mw; MemtoRegE = m2r; WA3E = wa;
        FlushE = 0;
        #1;
    endtask

    task automatic go_idle();
        ValidE = 0; FlushE = 0; BranchE = 0; PCSrcE = 0; RegWriteE = 0; MemWriteE = 0; MemtoRegE = 0;
        ALUControlE = 3'b000; FlagWriteE = 2'b00; CondE = 4'b1110;
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 0;
        ValidE = 0; RD1E = '0; RD2E = '0; ExtImmE = '0; ResultW = '0; ALUResultMFB = '0;
        ForwardAE = 0; ForwardBE = 0; ALUSrcE = 0; ALUControlE = 0; FlagWriteE = 0; CondE = 4'b1110;
        PCSrcE = 0; RegWriteE = 0; MemWriteE = 0; MemtoRegE = 0; BranchE = 0; WA3E = 0; FlushE = 0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst.FlagsD", 64'(FlagsD), 64'h0);
        check("rst.StallE", 64'(StallE), 64'h0);
        check("rst.ValidM", 64'(ValidM), 64'h0);
        check("rst.ALUResultM", 64'(ALUResultM), 64'h0);
        #2 reset = 1;
        @(posedge clk); #1;

        // ADD 5+7 with Op1 forwarded from W
        ResultW = 32'd5;
        drive(3'b000, 2'b01, 32'd99, 32'd7, 0, 32'd0, 2'b11, 4'b1110, 0, 0, 1, 0, 0, 4'd3);
        check("add.ALUResultEA", 64'(ALUResultEA), 64'd12);
        check("add.FlagsD", 64'(FlagsD), 64'h0);
        check("add.StallE", 64'(StallE), 64'h0);
        push_exp("add", 1, 0, 1, 0, 0, 32'd12, 32'd7, 4'd3);
        tick();

        // SUB 3-3 (immediate), store, sets Z and C
        drive(3'b001, 2'b00, 32'd3, 32'h55, 1, 32'd3, 2'b11, 4'b1110, 0, 0, 0, 1, 0, 4'd4);
        push_exp("sub0", 1, 0, 0, 1, 0, 32'd0, 32'h55, 4'd4);
        tick();

        // BEQ taken
        drive(3'b000, 2'b00, 32'h20, 32'd0, 1, 32'h100, 2'b00, 4'b0000, 1, 1, 0, 0, 0, 4'd0);
        check("beq.FlagsD", 64'(FlagsD), 64'b0110);
        check("beq.BranchTakenE", 64'(BranchTakenE), 64'd1);
        push_exp("beq", 1, 1, 0, 0, 0, 32'h120, 32'd0, 4'd0);
        tick();

        // BNE not taken: all M controls gated
        drive(3'b000, 2'b00, 32'h20, 32'd0, 1, 32'h100, 2'b00, 4'b0001, 1, 1, 1, 1, 1, 4'd5);
        check("bne.BranchTakenE", 64'(BranchTakenE), 64'd0);
        push_bubble("bne");
        tick();

        // Signed overflow on ADD
        drive(3'b000, 2'b00, 32'h7FFF_FFFF, 32'd1, 0, 32'd0, 2'b11, 4'b1110, 0, 0, 1, 0, 0, 4'd1);
        push_exp("addv", 1, 0, 1, 0, 0, 32'h8000_0000, 32'd1, 4'd1);
        tick();

        // GE true, LT false with N=1,V=1
        drive(3'b000, 2'b00, 32'd1, 32'd2, 0, 32'd0, 2'b00, 4'b1010, 0, 0, 1, 0, 0, 4'd2);
        check("ge.FlagsD", 64'(FlagsD), 64'b1001);
        push_exp("ge", 1, 0, 1, 0, 0, 32'd3, 32'd2, 4'd2);
        tick();
        drive(3'b000, 2'b00, 32'd1, 32'd2, 0, 32'd0, 2'b00, 4'b1011, 0, 0, 1, 0, 0, 4'd2);
        push_bubble("lt");
        tick();

        // SUB 0-1 writing C,V only: borrow gives C=0, N,Z held
        drive(3'b001, 2'b00, 32'd0, 32'd1, 0, 32'd0, 2'b01, 4'b1110, 0, 0, 1, 0, 0, 4'd6);
        push_exp("subcv", 1, 0, 1, 0, 0, 32'hFFFF_FFFF, 32'd1, 4'd6);
        tick();
        drive(3'b001, 2'b00, 32'd7, 32'd7, 0, 32'd0, 2'b11, 4'b1110, 0, 0, 0, 0, 0, 4'd0);
        check("subcv.FlagsD", 64'(FlagsD), 64'b1000);
        push_exp("sub7", 1, 0, 0, 0, 0, 32'd0, 32'd7, 4'd0);
        tick();

        // HI false / LS true with Z=1,C=1
        drive(3'b000, 2'b00, 32'd4, 32'd4, 0, 32'd0, 2'b00, 4'b1000, 0, 0, 1, 0, 0, 4'd8);
        check("hi.FlagsD", 64'(FlagsD), 64'b0110);
        push_bubble("hi");
        tick();
        drive(3'b000, 2'b00, 32'd4, 32'd4, 0, 32'd0, 2'b00, 4'b1001, 0, 0, 1, 0, 0, 4'd8);
        push_exp("ls", 1, 0, 1, 0, 0, 32'd8, 32'd4, 4'd8);
        tick();

        // MUL 0xFFFF x 0x10001: 32 stall cycles of bubbles, then DONE
        drive(3'b100, 2'b00, 32'h0000_FFFF, 32'h0001_0001, 0, 32'd0, 2'b11, 4'b1110, 0, 0, 1, 0, 0, 4'd7);
        for (int i = 0; i < MS; i++) begin
            check($sformatf("mul1.stall%0d", i), 64'(StallE), 64'd1);
            push_bubble($sformatf("mul1.b%0d", i));
            tick();
        end
        check("mul1.done.StallE", 64'(StallE), 64'd0);
        check("mul1.done.ALUResultEA", 64'(ALUResultEA), 64'hFFFF_FFFF);
        check("mul1.done.FlagsD", 64'(FlagsD), 64'b0110);
        push_exp("mul1", 1, 0, 1, 0, 0, 32'hFFFF_FFFF, 32'h0001_0001, 4'd7);
        tick();
        go_idle();
        check("mul1.flags", 64'(FlagsD), 64'b1010);
        check("mul1.idle.StallE", 64'(StallE), 64'd0);
`ifdef EXEC_STALL_CNT_EN
        check("mul1.StallCnt", 64'(StallCnt), 64'd32);
`endif

        // Flush in MUL cycle 10
        drive(3'b100, 2'b00, 32'd6, 32'd7, 0, 32'd0, 2'b11, 4'b1110, 0, 0, 1, 0, 0, 4'd9);
        for (int i = 0; i < 10; i++) begin
            push_bubble($sformatf("fl.b%0d", i));
            tick();
        end
        FlushE = 1; #1;
        check("fl.StallE_at_flush", 64'(StallE), 64'd1);
        push_bubble("fl.flush");
        tick();
        go_idle();
        check("fl.after.StallE", 64'(StallE), 64'd0);
        check("fl.after.FlagsD", 64'(FlagsD), 64'b1010);
        push_bubble("fl.gap");
        tick();
        drive(3'b000, 2'b00, 32'd1, 32'd1, 0, 32'd0, 2'b00, 4'b1110, 0, 0, 1, 0, 0, 4'd10);
        check("fl.add.StallE", 64'(StallE), 64'd0);
        push_exp("fl.add", 1, 0, 1, 0, 0, 32'd2, 32'd1, 4'd10);
        tick();

        // Flush wins over a simultaneous MUL start
        drive(3'b100, 2'b00, 32'd6, 32'd7, 0, 32'd0, 2'b11, 4'b1110, 0, 0, 1, 0, 0, 4'd9);
        FlushE = 1; #1;
        check("flst.StallE", 64'(StallE), 64'd0);
        push_bubble("flst");
        tick();
        go_idle();
        check("flst.next.StallE", 64'(StallE), 64'd0);
        push_bubble("flst.next");
        tick();

        // Reset mid-MUL aborts everything
        drive(3'b100, 2'b00, 32'd9, 32'd9, 0, 32'd0, 2'b11, 4'b1110, 0, 0, 1, 0, 0, 4'd11);
        for (int i = 0; i < 5; i++) begin
            push_bubble($sformatf("rm.b%0d", i));
            tick();
        end
        reset = 0;
        go_idle();
        check("rm.FlagsD", 64'(FlagsD), 64'h0);
        check("rm.StallE", 64'(StallE), 64'h0);
        check("rm.M.ctrl", 64'({ValidM, PCSrcM, RegWriteM, MemWriteM, MemtoRegM}), 64'h0);
        check("rm.M.data", 64'({ALUResultM, WriteDataM}), 64'h0);
        check("rm.WA3M", 64'(WA3M), 64'h0);
`ifdef EXEC_STALL_CNT_EN
        check("rm.StallCnt", 64'(StallCnt), 64'd0);
`endif
        #2 reset = 1;

        // Fresh MUL 3x4
        drive(3'b100, 2'b00, 32'd3, 32'd4, 0, 32'd0, 2'b00, 4'b1110, 0, 0, 1, 0, 0, 4'd2);
        for (int i = 0; i < MS; i++) begin
            check($sformatf("mul2.stall%0d", i), 64'(StallE), 64'd1);
            push_bubble($sformatf("mul2.b%0d", i));
            tick();
        end
        check("mul2.done.StallE", 64'(StallE), 64'd0);
        check("mul2.done.ALUResultEA", 64'(ALUResultEA), 64'd12);
        push_exp("mul2", 1, 0, 1, 0, 0, 32'd12, 32'd4, 4'd2);
        tick();
        go_idle();
        check("mul2.FlagsD", 64'(FlagsD), 64'h0);
`ifdef EXEC_STALL_CNT_EN
        check("mul2.StallCnt", 64'(StallCnt), 64'd32);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
